// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and default width for serial_sub_ctrl
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/sub_bit_cell.sv
// rtl/sub_bit_cell.sv - 1-bit full subtractor: d = x - y - c, bo = borrow out
module sub_bit_cell (
   input  logic x,
   input  logic y,
   input  logic c,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ c;
   assign bo = (~x & y) | (~(x ^ y) & c);

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial LSB-first subtractor a - b - bin, one bit per cycle
// Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_sub_ctrl
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   // One extra counter bit so the count can reach WIDTH without wrapping.
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             bout_q, bout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             cell_d, cell_bo;
`ifdef SERIAL_SUB_OVF_EN
   logic             msb_bin_q, msb_bin_d;
   logic             ovf_q, ovf_d;
`endif

   sub_bit_cell u_cell (
      .x  (a_q[0]),
      .y  (b_q[0]),
      .c  (borrow_q),
      .d  (cell_d),
      .bo (cell_bo)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      bout_d   = bout_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      msb_bin_d = msb_bin_q;
      ovf_d     = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d      = a;
               b_d      = b;
               borrow_d = bin;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            res_d    = {cell_d, res_q[WIDTH-1:1]};
            borrow_d = cell_bo;
            cnt_d    = cnt_q + 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            msb_bin_d = borrow_q;
`endif
            if (cnt_q == LAST_BIT) begin
               busy_d  = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            // borrow_q now holds the borrow out of the MSB cell.
            diff_d  = res_q;
            bout_d  = borrow_q;
            done_d  = 1'b1;
            state_d = IDLE;
`ifdef SERIAL_SUB_OVF_EN
            ovf_d = msb_bin_q ^ borrow_q;
`endif
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         msb_bin_q <= 1'b0;
         ovf_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         bout_q   <= bout_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
         msb_bin_q <= msb_bin_d;
         ovf_q     <= ovf_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - directed and randomized checks of serial_sub_ctrl against an arithmetic model
// Overflow checks are included when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       bin;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       bout;
`ifdef SERIAL_SUB_OVF_EN
   logic       ovf;
`endif

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   serial_sub_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic logic [7:0] ref_diff(input int ra, input int rb, input int rbin);
      int r;
      r = ra - rb - rbin;
      return 8'(r & 255);
   endfunction

   function automatic logic ref_bout(input int ra, input int rb, input int rbin);
      return (ra - rb - rbin) < 0;
   endfunction

   function automatic logic ref_ovf(input int ra, input int rb, input int rbin);
      int sa, sb, sr;
      sa = (ra >= 128) ? ra - 256 : ra;
      sb = (rb >= 128) ? rb - 256 : rb;
      sr = sa - sb - rbin;
      return (sr < -128) || (sr > 127);
   endfunction

   task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input logic tbin,
                         input bit repulse, input string tag);
      int         k;
      int         nb;
      int         extra;
      logic [7:0] d0;
      bit         stable;
      @(negedge clk);
      a     = ta;
      b     = tbv;
      bin   = tbin;
      start = 1'b1;
      @(posedge clk);
      k      = 99;
      nb     = 0;
      stable = 1'b1;
      d0     = '0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (i == 0) begin
            start = 1'b0;
            d0    = diff;
         end
         if (i == 1) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            bin = 1'($urandom);
         end
         if (repulse && i == 2) begin
            start = 1'b1;
            a     = 8'hFF;
         end
         if (repulse && i == 3) start = 1'b0;
         if (busy) nb++;
         if (done) begin
            k = i;
            break;
         end
         if (diff !== d0) stable = 1'b0;
      end
      check({tag, "_latency"}, k, 9);
      check({tag, "_busy_cycles"}, nb, 8);
      check({tag, "_diff_stable"}, 32'(stable), 1);
      check({tag, "_diff"}, diff, ref_diff(ta, tbv, tbin));
      check({tag, "_bout"}, bout, ref_bout(ta, tbv, tbin));
`ifdef SERIAL_SUB_OVF_EN
      check({tag, "_ovf"}, ovf, ref_ovf(ta, tbv, tbin));
`endif
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) extra++;
      end
      check({tag, "_single_done"}, extra, 0);
   endtask

   initial begin
      int         extra;
      int         cnt;
      logic [7:0] ca, cb;
      logic       cbin;
      logic [7:0] tbl_a [4];
      logic [7:0] tbl_b [4];
      logic       tbl_c [4];

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      #1;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_diff", diff, 0);
      check("reset_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
      check("reset_ovf", ovf, 0);
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_op(8'h05, 8'h03, 1'b0, 1'b0, "sub_5_3");
      run_op(8'h03, 8'h05, 1'b0, 1'b0, "sub_3_5");
      run_op(8'h00, 8'h00, 1'b1, 1'b0, "sub_0_0_bin");
      run_op(8'h80, 8'h01, 1'b0, 1'b0, "sub_80_01");
      run_op(8'h7F, 8'hFF, 1'b0, 1'b0, "sub_7f_ff");
      run_op(8'h05, 8'h03, 1'b0, 1'b1, "repulse");

      // Abort mid-operation; the prior nonzero result must clear at once.
      run_op(8'h03, 8'h05, 1'b0, 1'b0, "pre_abort");
      @(negedge clk);
      a     = 8'h44;
      b     = 8'h11;
      bin   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      repeat (3) @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_diff", diff, 0);
      check("abort_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
      check("abort_ovf", ovf, 0);
`endif
      @(negedge clk);
      rst   = 1'b0;
      extra = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) extra++;
      end
      check("abort_no_done", extra, 0);
      run_op(8'h10, 8'h01, 1'b0, 1'b0, "after_abort");

      for (int n = 0; n < 16; n++)
         run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "rand");

      // Back-to-back with start held high: corners first, then random operands.
      tbl_a[0] = 8'h00; tbl_b[0] = 8'h00; tbl_c[0] = 1'b0;
      tbl_a[1] = 8'hFF; tbl_b[1] = 8'hFF; tbl_c[1] = 1'b1;
      tbl_a[2] = 8'h00; tbl_b[2] = 8'hFF; tbl_c[2] = 1'b1;
      tbl_a[3] = 8'h80; tbl_b[3] = 8'h7F; tbl_c[3] = 1'b0;
      @(negedge clk);
      ca   = tbl_a[0];
      cb   = tbl_b[0];
      cbin = tbl_c[0];
      a     = ca;
      b     = cb;
      bin   = cbin;
      start = 1'b1;
      for (int n = 0; n < 40; n++) begin
         cnt = 99;
         for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
               cnt = i;
               break;
            end
         end
         check("b2b_period", cnt, 10);
         check("b2b_diff", diff, ref_diff(ca, cb, cbin));
         check("b2b_bout", bout, ref_bout(ca, cb, cbin));
`ifdef SERIAL_SUB_OVF_EN
         check("b2b_ovf", ovf, ref_ovf(ca, cb, cbin));
`endif
         if (n + 1 < 4) begin
            ca   = tbl_a[n+1];
            cb   = tbl_b[n+1];
            cbin = tbl_c[n+1];
         end else begin
            ca   = 8'($urandom);
            cb   = 8'($urandom);
            cbin = 1'($urandom);
         end
         a   = ca;
         b   = cb;
         bin = cbin;
         if (n == 39) start = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
